// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that merges several AXI-Stream packet sources onto the single
// slave port of a uart_tx. It can force an idle gap after each packet and truncate overlong packets.
module uart_tx_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = 4,
   parameter int GAP_CYCLES = 2,
   parameter int MAX_BEATS  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid_i,
   input  logic [NUM_SRC-1:0]            s_axis_tlast_i,
   output logic [NUM_SRC-1:0]            s_axis_tready_o,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata_o,
   output logic                          m_axis_tvalid_o,
   output logic                          m_axis_tlast_o,
   input  logic                          m_axis_tready_i,
   input  logic [NUM_SRC-1:0]            src_en_i,
   output logic [NUM_SRC-1:0]            grant_o,
   output logic                          busy_o,
   output logic                          trunc_err_o,
   output logic [15:0]                   pkt_cnt_o
);

   localparam int              IDXW      = $clog2(NUM_SRC);
   localparam logic [15:0]     LAST_BEAT = 16'(MAX_BEATS - 1);
   localparam logic [7:0]      GAP_LOAD  = 8'(GAP_CYCLES);
   localparam logic [IDXW-1:0] LAST_SRC  = IDXW'(NUM_SRC - 1);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t              state_q, state_d;
   logic [NUM_SRC-1:0]  grant_q, grant_d;
   logic [IDXW-1:0]     lastGrant_q, lastGrant_d;
   logic [15:0]         beatCnt_q, beatCnt_d;
   logic [7:0]          gapCnt_q, gapCnt_d;
   logic [15:0]         pktCnt_q, pktCnt_d;
   logic                truncErr_q, truncErr_d;

   logic [NUM_SRC-1:0]  eligible;
   logic                found;
   logic [IDXW-1:0]     pickIdx;
   logic [IDXW-1:0]     cand;
   logic                srcLast;
   logic                forceLast;
   logic                beat;

   assign eligible  = s_axis_tvalid_i & src_en_i;
   assign srcLast   = s_axis_tlast_i[lastGrant_q];
   assign forceLast = (beatCnt_q == LAST_BEAT);
   assign beat      = (state_q == XFER) && s_axis_tvalid_i[lastGrant_q] && m_axis_tready_i;

   // Walk the sources starting just after the previous winner, wrapping at NUM_SRC.
   always_comb begin
      found   = 1'b0;
      pickIdx = lastGrant_q;
      cand    = lastGrant_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = (cand == LAST_SRC) ? '0 : cand + 1'b1;
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            pickIdx = cand;
         end
      end
   end

   // The grant index stays in lastGrant_q for the whole packet, so it also steers the mux.
   always_comb begin
      m_axis_tdata_o  = '0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      s_axis_tready_o = '0;
      if (state_q == XFER) begin
         m_axis_tdata_o                  = s_axis_tdata_i[lastGrant_q*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid_o                 = s_axis_tvalid_i[lastGrant_q];
         m_axis_tlast_o                  = srcLast | forceLast;
         s_axis_tready_o[lastGrant_q]    = m_axis_tready_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      beatCnt_d   = beatCnt_q;
      gapCnt_d    = gapCnt_q;
      pktCnt_d    = pktCnt_q;
      truncErr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d          = '0;
               grant_d[pickIdx] = 1'b1;
               lastGrant_d      = pickIdx;
               beatCnt_d        = '0;
               state_d          = XFER;
            end
         end
         XFER: begin
            if (beat) begin
               beatCnt_d = beatCnt_q + 16'd1;
               if (srcLast || forceLast) begin
                  grant_d    = '0;
                  pktCnt_d   = pktCnt_q + 16'd1;
                  truncErr_d = forceLast && !srcLast;
                  if (GAP_CYCLES > 0) begin
                     state_d  = GAP;
                     gapCnt_d = GAP_LOAD;
                  end else begin
                     state_d  = IDLE;
                  end
               end
            end
         end
         GAP: begin
            gapCnt_d = gapCnt_q - 8'd1;
            if (gapCnt_q <= 8'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= LAST_SRC;
         beatCnt_q   <= '0;
         gapCnt_q    <= '0;
         pktCnt_q    <= '0;
         truncErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         beatCnt_q   <= beatCnt_d;
         gapCnt_q    <= gapCnt_d;
         pktCnt_q    <= pktCnt_d;
         truncErr_q  <= truncErr_d;
      end
   end

   assign grant_o     = grant_q;
   assign busy_o      = (state_q == XFER) || (state_q == GAP);
   assign trunc_err_o = truncErr_q;
   assign pkt_cnt_o   = pktCnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a per-cycle vector table plus hand-written sequences
// for round-robin order, enable masking, truncation and a zero-gap instance.
module tb_uart_tx_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  en, vld, lst;
   logic [31:0] dat;
   logic        rdy;

   logic [3:0]  trdy, grant;
   logic [7:0]  mdat;
   logic        mvld, mlst, busy, trunc;
   logic [15:0] pkt;

   logic [3:0]  ztrdy, zgrant;
   logic [7:0]  zmdat;
   logic        zmvld, zmlst, zbusy, ztrunc;
   logic [15:0] zpkt;

   int total = 0;
   int bad   = 0;

   uart_tx_arb #(.DATA_WIDTH(8), .NUM_SRC(4), .GAP_CYCLES(2), .MAX_BEATS(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata_i(dat), .s_axis_tvalid_i(vld), .s_axis_tlast_i(lst), .s_axis_tready_o(trdy),
      .m_axis_tdata_o(mdat), .m_axis_tvalid_o(mvld), .m_axis_tlast_o(mlst), .m_axis_tready_i(rdy),
      .src_en_i(en), .grant_o(grant), .busy_o(busy), .trunc_err_o(trunc), .pkt_cnt_o(pkt)
   );

   uart_tx_arb #(.DATA_WIDTH(8), .NUM_SRC(4), .GAP_CYCLES(0), .MAX_BEATS(16)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata_i(dat), .s_axis_tvalid_i(vld), .s_axis_tlast_i(lst), .s_axis_tready_o(ztrdy),
      .m_axis_tdata_o(zmdat), .m_axis_tvalid_o(zmvld), .m_axis_tlast_o(zmlst), .m_axis_tready_i(rdy),
      .src_en_i(en), .grant_o(zgrant), .busy_o(zbusy), .trunc_err_o(ztrunc), .pkt_cnt_o(zpkt)
   );

   typedef struct {
      logic        r;
      logic [3:0]  e, v, l;
      logic [31:0] d;
      logic        rd;
      logic [3:0]  eg;
      logic        emv;
      logic [7:0]  emd;
      logic        eml;
      logic [3:0]  etr;
      logic        eb;
      logic [15:0] ep;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(logic r, logic [3:0] e, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                               logic rd, logic [3:0] eg, logic emv, logic [7:0] emd, logic eml,
                               logic [3:0] etr, logic eb, logic [15:0] ep);
      vec_t x;
      x.r = r; x.e = e; x.v = v; x.l = l; x.d = d; x.rd = rd;
      x.eg = eg; x.emv = emv; x.emd = emd; x.eml = eml; x.etr = etr; x.eb = eb; x.ep = ep;
      return x;
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rise.
   task automatic applyStimulus(input logic r, input logic [3:0] e, input logic [3:0] v,
                                input logic [3:0] l, input logic [31:0] d, input logic rd);
      @(negedge clk);
      rst = r; en = e; vld = v; lst = l; dat = d; rdy = rd;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One 1-beat packet: IDLE cycle, XFER cycle, then two GAP cycles.
   task automatic runRound(input int src, input logic [3:0] enV, input logic [15:0] pktBefore);
      logic [3:0] expG;
      expG = 4'b0001 << src;
      applyStimulus(1'b0, enV, 4'hF, 4'hF, 32'h43424140, 1'b1);
      checkOutput("rr_idle_grant", 32'(grant), 32'h0);
      checkOutput("rr_idle_busy", 32'(busy), 32'h0);
      applyStimulus(1'b0, enV, 4'hF, 4'hF, 32'h43424140, 1'b1);
      checkOutput($sformatf("rr_grant_src%0d", src), 32'(grant), 32'(expG));
      checkOutput("rr_mvld", 32'(mvld), 32'h1);
      checkOutput("rr_mdat", 32'(mdat), 32'h40 + src);
      checkOutput("rr_pkt_before", 32'(pkt), 32'(pktBefore));
      for (int g = 0; g < 2; g++) begin
         applyStimulus(1'b0, enV, 4'hF, 4'hF, 32'h43424140, 1'b1);
         checkOutput("rr_gap_grant", 32'(grant), 32'h0);
         checkOutput("rr_gap_busy", 32'(busy), 32'h1);
         checkOutput("rr_gap_mvld", 32'(mvld), 32'h0);
         checkOutput("rr_gap_pkt", 32'(pkt), 32'(pktBefore) + 1);
      end
   endtask

   initial begin
      rst = 1'b1; en = 4'h0; vld = 4'h0; lst = 4'h0; dat = 32'h0; rdy = 1'b0;

      // Reset state
      applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_mvld", 32'(mvld), 32'h0);
      checkOutput("rst_trdy", 32'(trdy), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_pkt", 32'(pkt), 32'h0);
      checkOutput("rst_trunc", 32'(trunc), 32'h0);

      // Single source, back-pressure with a tvalid drop, then reset mid-packet
      vecs[0]  = mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'hEEA1EEEE, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd0);
      vecs[1]  = mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'hEEA1EEEE, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 4'b0100, 1'b1, 16'd0);
      vecs[2]  = mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'hEEA2EEEE, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 4'b0100, 1'b1, 16'd0);
      vecs[3]  = mk(1'b0, 4'hF, 4'b0100, 4'b0100, 32'hEEA3EEEE, 1'b1, 4'b0100, 1'b1, 8'hA3, 1'b1, 4'b0100, 1'b1, 16'd0);
      vecs[4]  = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[5]  = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[6]  = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd1);
      vecs[7]  = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB1EEEEEE, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd1);
      vecs[8]  = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB1EEEEEE, 1'b1, 4'b1000, 1'b1, 8'hB1, 1'b0, 4'b1000, 1'b1, 16'd1);
      vecs[9]  = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB2EEEEEE, 1'b0, 4'b1000, 1'b1, 8'hB2, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[10] = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB2EEEEEE, 1'b0, 4'b1000, 1'b1, 8'hB2, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[11] = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB2EEEEEE, 1'b1, 4'b1000, 1'b1, 8'hB2, 1'b0, 4'b1000, 1'b1, 16'd1);
      vecs[12] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'hB3EEEEEE, 1'b1, 4'b1000, 1'b0, 8'h00, 1'b0, 4'b1000, 1'b1, 16'd1);
      vecs[13] = mk(1'b0, 4'hF, 4'b1000, 4'b0000, 32'hB3EEEEEE, 1'b1, 4'b1000, 1'b1, 8'hB3, 1'b0, 4'b1000, 1'b1, 16'd1);
      vecs[14] = mk(1'b0, 4'hF, 4'b1000, 4'b1000, 32'hB4EEEEEE, 1'b1, 4'b1000, 1'b1, 8'hB4, 1'b1, 4'b1000, 1'b1, 16'd1);
      vecs[15] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd2);
      vecs[16] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd2);
      vecs[17] = mk(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEEC1EE, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd2);
      vecs[18] = mk(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEEC1EE, 1'b1, 4'b0010, 1'b1, 8'hC1, 1'b0, 4'b0010, 1'b1, 16'd2);
      vecs[19] = mk(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEEC2EE, 1'b1, 4'b0010, 1'b1, 8'hC2, 1'b0, 4'b0010, 1'b1, 16'd2);
      vecs[20] = mk(1'b1, 4'hF, 4'b0010, 4'b0000, 32'hEEEEC3EE, 1'b1, 4'b0010, 1'b1, 8'hC3, 1'b0, 4'b0010, 1'b1, 16'd2);
      vecs[21] = mk(1'b0, 4'hF, 4'b1001, 4'b0000, 32'hD3EEEED0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd0);
      vecs[22] = mk(1'b0, 4'hF, 4'b1001, 4'b1001, 32'hD3EEEED0, 1'b1, 4'b0001, 1'b1, 8'hD0, 1'b1, 4'b0001, 1'b1, 16'd0);
      vecs[23] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[24] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 16'd1);
      vecs[25] = mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 16'd1);

      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].rd);
         checkOutput($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].eg));
         checkOutput($sformatf("v%0d_mvld", i), 32'(mvld), 32'(vecs[i].emv));
         checkOutput($sformatf("v%0d_trdy", i), 32'(trdy), 32'(vecs[i].etr));
         checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
         checkOutput($sformatf("v%0d_pkt", i), 32'(pkt), 32'(vecs[i].ep));
         checkOutput($sformatf("v%0d_trunc", i), 32'(trunc), 32'h0);
         if (vecs[i].emv) begin
            checkOutput($sformatf("v%0d_mdat", i), 32'(mdat), 32'(vecs[i].emd));
            checkOutput($sformatf("v%0d_mlst", i), 32'(mlst), 32'(vecs[i].eml));
         end
      end

      // All four sources continuously requesting: 0,1,2,3,0
      applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      runRound(0, 4'hF, 16'd0);
      runRound(1, 4'hF, 16'd1);
      runRound(2, 4'hF, 16'd2);
      runRound(3, 4'hF, 16'd3);
      runRound(0, 4'hF, 16'd4);

      // Source 1 disabled: 0,2,3,0
      applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      runRound(0, 4'b1101, 16'd0);
      runRound(2, 4'b1101, 16'd1);
      runRound(3, 4'b1101, 16'd2);
      runRound(0, 4'b1101, 16'd3);

      // Enable dropped while source 0 owns the port
      applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 4'hF, 4'b0001, 4'b0000, 32'hEEEEEEE0, 1'b1);
      checkOutput("en_idle_grant", 32'(grant), 32'h0);
      applyStimulus(1'b0, 4'hF, 4'b0001, 4'b0000, 32'hEEEEEEE1, 1'b1);
      checkOutput("en_beat1_grant", 32'(grant), 32'h1);
      checkOutput("en_beat1_mdat", 32'(mdat), 32'hE1);
      applyStimulus(1'b0, 4'h0, 4'b0001, 4'b0001, 32'hEEEEEEE2, 1'b1);
      checkOutput("en_beat2_grant", 32'(grant), 32'h1);
      checkOutput("en_beat2_mvld", 32'(mvld), 32'h1);
      checkOutput("en_beat2_mlst", 32'(mlst), 32'h1);
      checkOutput("en_beat2_trdy", 32'(trdy), 32'h1);
      applyStimulus(1'b0, 4'h0, 4'b0000, 4'b0000, 32'h0, 1'b1);
      checkOutput("en_after_grant", 32'(grant), 32'h0);
      checkOutput("en_after_pkt", 32'(pkt), 32'h1);

      // Source 1 streams without tlast: truncated at beat 16
      applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE00EE, 1'b1);
      checkOutput("tr_idle_grant", 32'(grant), 32'h0);
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE00EE | (32'(i) << 8), 1'b1);
         checkOutput($sformatf("tr_b%0d_grant", i), 32'(grant), 32'h2);
         checkOutput($sformatf("tr_b%0d_mdat", i), 32'(mdat), 32'(i));
         checkOutput($sformatf("tr_b%0d_mlst", i), 32'(mlst), (i == 16) ? 32'h1 : 32'h0);
         checkOutput($sformatf("tr_b%0d_trunc", i), 32'(trunc), 32'h0);
      end
      applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE11EE, 1'b1);
      checkOutput("tr_gap1_trunc", 32'(trunc), 32'h1);
      checkOutput("tr_gap1_grant", 32'(grant), 32'h0);
      checkOutput("tr_gap1_pkt", 32'(pkt), 32'h1);
      checkOutput("tr_gap1_mvld", 32'(mvld), 32'h0);
      applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE12EE, 1'b1);
      checkOutput("tr_gap2_trunc", 32'(trunc), 32'h0);
      checkOutput("tr_gap2_busy", 32'(busy), 32'h1);
      applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE13EE, 1'b1);
      checkOutput("tr_idle2_busy", 32'(busy), 32'h0);
      checkOutput("tr_idle2_trunc", 32'(trunc), 32'h0);
      applyStimulus(1'b0, 4'hF, 4'b0010, 4'b0000, 32'hEEEE14EE, 1'b1);
      checkOutput("tr_regrant", 32'(grant), 32'h2);
      checkOutput("tr_regrant_mdat", 32'(mdat), 32'h14);

      // Zero-gap instance: grant every other cycle
      applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      for (int p = 0; p < 4; p++) begin
         applyStimulus(1'b0, 4'hF, 4'hF, 4'hF, 32'h43424140, 1'b1);
         checkOutput($sformatf("g0_idle%0d_grant", p), 32'(zgrant), 32'h0);
         checkOutput($sformatf("g0_idle%0d_busy", p), 32'(zbusy), 32'h0);
         applyStimulus(1'b0, 4'hF, 4'hF, 4'hF, 32'h43424140, 1'b1);
         checkOutput($sformatf("g0_x%0d_grant", p), 32'(zgrant), 32'h1 << p);
         checkOutput($sformatf("g0_x%0d_trdy", p), 32'(ztrdy), 32'h1 << p);
         checkOutput($sformatf("g0_x%0d_mvld", p), 32'(zmvld), 32'h1);
         checkOutput($sformatf("g0_x%0d_mdat", p), 32'(zmdat), 32'h40 + p);
         checkOutput($sformatf("g0_x%0d_mlst", p), 32'(zmlst), 32'h1);
         checkOutput($sformatf("g0_x%0d_busy", p), 32'(zbusy), 32'h1);
      end
      applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b1);
      checkOutput("g0_pkt", 32'(zpkt), 32'h4);
      checkOutput("g0_trunc", 32'(ztrunc), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
